// File: rtl/mtm_alu_serializer_if.sv
// Result handshake and serial-pin bundle between the ALU core and the transmit serializer.
interface mtm_alu_serializer_if;
  logic        res_valid;
  logic        res_ack;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [2:0]  crc;
  logic        op_err;
  logic        sout;
  logic        busy;

  modport master (
    output res_valid, result, flags, crc, op_err,
    input  res_ack, sout, busy
  );

  modport slave (
    input  res_valid, result, flags, crc, op_err,
    output res_ack, sout, busy
  );
endinterface

// File: rtl/mtm_alu_serializer.sv
// ALU result serializer: 5-byte result frame or 1-byte error frame, 11 bits per byte, MSB first.
// Optional macro SER_BAUD_DIV_EN stretches every bit to CLKS_PER_BIT clocks.
module mtm_alu_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mtm_alu_serializer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, CTL, DATA, STOP} state_t;

  localparam logic [6:0] ERR_HI   = 7'b1001001;
  localparam logic [7:0] ERR_BYTE = {ERR_HI, ^ERR_HI};

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [2:0]  byte_cnt, byte_cnt_n;
  logic        capture, capture_err;
  logic [31:0] res_q;
  logic [3:0]  flags_q;
  logic [2:0]  crc_q;
  logic        err_q;
  logic        err_pend;
  logic        op_err_q;
  logic        ack_q;
  logic        err_evt;
  logic        tick;
  logic [7:0]  cur_byte;
  logic        cur_ctl;
  logic [2:0]  last_byte;
  logic        sout_c;

  assign err_evt   = bus.op_err & ~op_err_q;
  assign last_byte = err_q ? 3'd0 : 3'd4;

`ifdef SER_BAUD_DIV_EN
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  logic [BW-1:0] baud_cnt;

  assign tick = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || capture)
      baud_cnt <= '0;
    else if (state != IDLE)
      baud_cnt <= tick ? '0 : baud_cnt + BW'(1);
  end
`else
  // Without the divider every bit is one clock; the parameter only keeps the port list stable.
  logic unused_clks;
  assign unused_clks = ^CLKS_PER_BIT;
  assign tick = 1'b1;
`endif

  // Select the byte currently on the line from the frozen capture.
  always_comb begin
    cur_byte = 8'h00;
    cur_ctl  = 1'b0;
    if (err_q) begin
      cur_byte = ERR_BYTE;
      cur_ctl  = 1'b1;
    end else begin
      unique case (byte_cnt)
        3'd0: cur_byte = res_q[31:24];
        3'd1: cur_byte = res_q[23:16];
        3'd2: cur_byte = res_q[15:8];
        3'd3: cur_byte = res_q[7:0];
        3'd4: begin
          cur_byte = {1'b0, flags_q, crc_q};
          cur_ctl  = 1'b1;
        end
        default: cur_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    byte_cnt_n  = byte_cnt;
    capture     = 1'b0;
    capture_err = 1'b0;
    sout_c      = 1'b1;
    unique case (state)
      IDLE: begin
        byte_cnt_n = 3'd0;
        bit_cnt_n  = 3'd0;
        // A pending or fresh error wins; a simultaneous result is still acked and dropped.
        if (err_pend || err_evt) begin
          capture     = 1'b1;
          capture_err = 1'b1;
          state_n     = START;
        end else if (bus.res_valid) begin
          capture = 1'b1;
          state_n = START;
        end
      end
      START: begin
        sout_c = 1'b0;
        if (tick) state_n = CTL;
      end
      CTL: begin
        sout_c = cur_ctl;
        if (tick) begin
          state_n   = DATA;
          bit_cnt_n = 3'd7;
        end
      end
      DATA: begin
        sout_c = cur_byte[bit_cnt];
        if (tick) begin
          if (bit_cnt == 3'd0) state_n = STOP;
          else                 bit_cnt_n = bit_cnt - 3'd1;
        end
      end
      STOP: begin
        sout_c = 1'b1;
        if (tick) begin
          if (byte_cnt < last_byte) begin
            byte_cnt_n = byte_cnt + 3'd1;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      byte_cnt <= 3'd0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
    end
  end

  // Reset holds op_err_q high so a level already asserted is not seen as a new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_err_q <= 1'b1;
      err_pend <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      op_err_q <= bus.op_err;
      ack_q    <= capture & bus.res_valid;
      if (capture_err)  err_pend <= 1'b0;
      else if (err_evt) err_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= 32'h0;
      flags_q <= 4'h0;
      crc_q   <= 3'h0;
      err_q   <= 1'b0;
    end else if (capture) begin
      err_q <= capture_err;
      if (!capture_err) begin
        res_q   <= bus.result;
        flags_q <= bus.flags;
        crc_q   <= bus.crc;
      end
    end
  end

  assign bus.sout    = sout_c;
  assign bus.busy    = (state != IDLE);
  assign bus.res_ack = ack_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Randomized bench for mtm_alu_serializer against a frame-level model of the serial line.
module tb_mtm_alu_serializer;

`ifdef SER_BAUD_DIV_EN
  localparam int CPB = 4;
`else
  localparam int CPB = 1;
`endif
  localparam int F = 55 * CPB;
  localparam int E = 11 * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mtm_alu_serializer_if bus();
  mtm_alu_serializer #(.CLKS_PER_BIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests_run = 0;
  int tests_failed = 0;

  bit obs_s[$], obs_b[$], obs_a[$];
  bit exp_s[$], exp_b[$], exp_a[$];

  bit          chain;
  logic [31:0] nres;
  logic [3:0]  nflags;
  logic [2:0]  ncrc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int first_diff(input bit a[$], input bit b[$]);
    if (a.size() != b.size()) return 0;
    foreach (b[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic exp_clear();
    exp_s.delete(); exp_b.delete(); exp_a.delete();
  endtask

  task automatic exp_idle(input int n);
    repeat (n) begin exp_s.push_back(1'b1); exp_b.push_back(1'b0); exp_a.push_back(1'b0); end
  endtask

  task automatic exp_pad(input int n);
    while (exp_s.size() < n) exp_idle(1);
  endtask

  // One byte on the line: start 0, ctl, data MSB first, stop 1.
  task automatic exp_byte(input bit ctl, input logic [7:0] d);
    bit b;
    for (int k = 0; k < 11; k++) begin
      if (k == 0)       b = 1'b0;
      else if (k == 1)  b = ctl;
      else if (k == 10) b = 1'b1;
      else              b = d[9-k];
      repeat (CPB) begin exp_s.push_back(b); exp_b.push_back(1'b1); exp_a.push_back(1'b0); end
    end
  endtask

  task automatic exp_good(input logic [31:0] r, input logic [3:0] fl, input logic [2:0] cr);
    for (int k = 0; k < 4; k++) exp_byte(1'b0, r[31-8*k -: 8]);
    exp_byte(1'b1, {1'b0, fl, cr});
  endtask

  task automatic exp_err();
    exp_byte(1'b1, 8'h93);
  endtask

  task automatic preamble();
    rst = 1'b0; bus.res_valid = 1'b0; bus.op_err = 1'b0; chain = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic observe(input int ncyc, input int valid_hold, input int err_at, input int rst_at);
    int since_ack;
    since_ack = -1;
    obs_s.delete(); obs_b.delete(); obs_a.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      obs_s.push_back(bus.sout); obs_b.push_back(bus.busy); obs_a.push_back(bus.res_ack);
      rst = 1'b0;
      if (bus.res_ack) begin
        if (chain) begin
          chain = 1'b0; bus.result = nres; bus.flags = nflags; bus.crc = ncrc; since_ack = -1;
        end else since_ack = 0;
      end else if (since_ack >= 0) since_ack++;
      if (since_ack >= valid_hold) bus.res_valid = 1'b0;
      if (i == err_at) bus.op_err = 1'b1;
      if (i == rst_at) rst = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.res_valid = 1'b0; bus.op_err = 1'b1;
    bus.result = '0; bus.flags = '0; bus.crc = '0; chain = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.sout !== 1'b1) begin tests_failed++; $display("FAIL reset_sout: got %b required 1", bus.sout); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    tests_run++; if (bus.res_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b required 0", bus.res_ack); end
    rst = 1'b0;
    exp_clear(); exp_pad(15);
    observe(15, 0, -1, -1);
    tests_run++; if (first_diff(obs_s, exp_s) != -1) begin tests_failed++; $display("FAIL reset_held_err_sout: line left idle at cycle %0d", first_diff(obs_s, exp_s)); end
    tests_run++; if (first_diff(obs_b, exp_b) != -1) begin tests_failed++; $display("FAIL reset_held_err_busy: got busy at cycle %0d required 0", first_diff(obs_b, exp_b)); end
  endtask

  task automatic test_good(input string name, input logic [31:0] r, input logic [3:0] fl,
                           input logic [2:0] cr, input int hold);
    int d;
    preamble();
    bus.result = r; bus.flags = fl; bus.crc = cr; bus.res_valid = 1'b1;
    exp_clear(); exp_good(r, fl, cr); exp_a[0] = 1'b1; exp_pad(F + 8);
    observe(F + 8, hold, -1, -1);
    d = first_diff(obs_s, exp_s);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL %s_sout: cycle %0d got %b required %b", name, d, obs_s[d], exp_s[d]); end
    d = first_diff(obs_b, exp_b);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL %s_busy: cycle %0d got %b required %b", name, d, obs_b[d], exp_b[d]); end
    d = first_diff(obs_a, exp_a);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL %s_ack: cycle %0d got %b required %b", name, d, obs_a[d], exp_a[d]); end
  endtask

  task automatic test_error_only();
    int d;
    preamble();
    bus.op_err = 1'b1;
    exp_clear(); exp_err(); exp_pad(E + 8);
    observe(E + 8, 0, -1, -1);
    d = first_diff(obs_s, exp_s);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL err_sout: cycle %0d got %b required %b", d, obs_s[d], exp_s[d]); end
    d = first_diff(obs_b, exp_b);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL err_busy: cycle %0d got %b required %b", d, obs_b[d], exp_b[d]); end
    d = first_diff(obs_a, exp_a);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL err_ack: cycle %0d got %b required %b", d, obs_a[d], exp_a[d]); end
  endtask

  task automatic test_err_during_frame();
    int d;
    logic [31:0] r;
    r = $urandom();
    preamble();
    bus.result = r; bus.flags = 4'hA; bus.crc = 3'h6; bus.res_valid = 1'b1;
    exp_clear(); exp_good(r, 4'hA, 3'h6); exp_a[0] = 1'b1; exp_idle(1); exp_err(); exp_pad(F + 1 + E + 6);
    observe(F + 1 + E + 6, 0, 10 * CPB, -1);
    d = first_diff(obs_s, exp_s);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL pend_sout: cycle %0d got %b required %b", d, obs_s[d], exp_s[d]); end
    d = first_diff(obs_b, exp_b);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL pend_busy: cycle %0d got %b required %b", d, obs_b[d], exp_b[d]); end
    d = first_diff(obs_a, exp_a);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL pend_ack: cycle %0d got %b required %b", d, obs_a[d], exp_a[d]); end
  endtask

  task automatic test_simultaneous();
    int d;
    preamble();
    bus.result = $urandom(); bus.flags = 4'h5; bus.crc = 3'h2;
    bus.res_valid = 1'b1; bus.op_err = 1'b1;
    exp_clear(); exp_err(); exp_a[0] = 1'b1; exp_pad(E + 8);
    observe(E + 8, 0, -1, -1);
    d = first_diff(obs_s, exp_s);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL simul_sout: cycle %0d got %b required %b", d, obs_s[d], exp_s[d]); end
    d = first_diff(obs_b, exp_b);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL simul_busy: cycle %0d got %b required %b", d, obs_b[d], exp_b[d]); end
    d = first_diff(obs_a, exp_a);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL simul_ack: cycle %0d got %b required %b", d, obs_a[d], exp_a[d]); end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [31:0] ra;
    ra = $urandom(); nres = $urandom(); nflags = 4'($urandom()); ncrc = 3'($urandom());
    preamble();
    bus.result = ra; bus.flags = 4'h3; bus.crc = 3'h1; bus.res_valid = 1'b1; chain = 1'b1;
    exp_clear(); exp_good(ra, 4'h3, 3'h1); exp_idle(1); exp_good(nres, nflags, ncrc);
    exp_a[0] = 1'b1; exp_a[F+1] = 1'b1; exp_pad(2 * F + 7);
    observe(2 * F + 7, 0, -1, -1);
    d = first_diff(obs_s, exp_s);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL b2b_sout: cycle %0d got %b required %b", d, obs_s[d], exp_s[d]); end
    d = first_diff(obs_b, exp_b);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL b2b_busy: cycle %0d got %b required %b", d, obs_b[d], exp_b[d]); end
    d = first_diff(obs_a, exp_a);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL b2b_ack: cycle %0d got %b required %b", d, obs_a[d], exp_a[d]); end
  endtask

  task automatic test_rst_mid_frame();
    int d;
    logic [31:0] r;
    r = $urandom();
    preamble();
    bus.result = r; bus.flags = 4'h7; bus.crc = 3'h4; bus.res_valid = 1'b1;
    exp_clear(); exp_good(r, 4'h7, 3'h4); exp_a[0] = 1'b1;
    while (exp_s.size() > 20 * CPB + 1) begin
      void'(exp_s.pop_back()); void'(exp_b.pop_back()); void'(exp_a.pop_back());
    end
    exp_pad(F + 8);
    observe(F + 8, 0, -1, 20 * CPB);
    d = first_diff(obs_s, exp_s);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL rstmid_sout: cycle %0d got %b required %b", d, obs_s[d], exp_s[d]); end
    d = first_diff(obs_b, exp_b);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL rstmid_busy: cycle %0d got %b required %b", d, obs_b[d], exp_b[d]); end
    d = first_diff(obs_a, exp_a);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL rstmid_ack: cycle %0d got %b required %b", d, obs_a[d], exp_a[d]); end
    test_good("after_rst", $urandom(), 4'($urandom()), 3'($urandom()), 0);
  endtask

  initial begin
    test_reset();
    test_good("directed", 32'h12345678, 4'b0000, 3'b101, 0);
    for (int i = 0; i < 4; i++)
      test_good($sformatf("rand%0d", i), $urandom(), 4'($urandom()), 3'($urandom()), 0);
    test_error_only();
    test_err_during_frame();
    test_simultaneous();
    test_good("linger", $urandom(), 4'($urandom()), 3'($urandom()), 2);
    test_back_to_back();
    test_rst_mid_frame();
    test_good("baud_vec", 32'hFFFFFFFF, 4'b1000, 3'b011, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
